// File: rtl/serial_addsub_if.sv
// Handshake bundle for the bit-serial add/subtract unit: operand request side and
// result response side, each with its own valid/ready pair.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start_valid, a, b, op, res_ready,
    input  start_ready, res_valid, result, cout, overflow
  );

  modport slave (
    input  start_valid, a, b, op, res_ready,
    output start_ready, res_valid, result, cout, overflow
  );
endinterface

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock, LSB first.
// Subtraction is A + ~B + 1, with the +1 injected as the initial carry.
module serial_addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             start_ready, res_valid;
  logic             fa_sum, fa_cy;

  // The single full-adder cell shared across all bit positions
  assign fa_sum = sa_q[0] ^ sb_q[0] ^ c_q;
  assign fa_cy  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    acc_d       = acc_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (bus.start_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.op ? ~bus.b : bus.b;
          c_d     = bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = fa_cy;
        acc_d = {fa_sum, acc_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Published result only updates on completion, so it stays stable while busy
        if (cnt_q == LAST) begin
          res_d   = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d  = fa_cy;
          ovf_d   = c_q ^ fa_cy;
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = res_valid;
  assign bus.result      = res_q;
  assign bus.cout        = cout_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench: drivers push expected results at accept, monitors pop on each
// result handshake. An 8-bit unit covers directed cases, a 3-bit unit is swept fully.
module tb_serial_addsub_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(3)) bus3 ();

  serial_addsub_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub_unit #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb8[$];
  exp_t sb3[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus8.res_valid && bus8.res_ready) begin
      if (sb8.size() == 0) chk("unexpected_res8", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb8.pop_front();
        chk("res8", {23'd0, bus8.result, bus8.cout}, {23'd0, e.res, e.c});
        chk("ovf8", {31'd0, bus8.overflow}, {31'd0, e.v});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus3.res_valid && bus3.res_ready) begin
      if (sb3.size() == 0) chk("unexpected_res3", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb3.pop_front();
        chk("res3", {27'd0, bus3.result, bus3.cout, bus3.overflow},
                    {27'd0, e.res[2:0], e.c, e.v});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op to the 8-bit unit; hold>0 keeps res_ready low that many cycles in DONE
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic op,
                        input logic [7:0] er, input logic ec, input logic ev, input int hold);
    int n;
    bus8.a = a; bus8.b = b; bus8.op = op;
    bus8.start_valid = 1'b1;
    bus8.res_ready = (hold == 0);
    n = 0;
    while (!bus8.start_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("start_ready_timeout", 32'd0, 32'd1);
    sb8.push_back('{res: er, c: ec, v: ev});
    tick();
    bus8.start_valid = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.op = ~op;
    n = 0;
    while (!bus8.res_valid && n < 100) begin tick(); n++; end
    chk("latency", n, 8);
    for (int i = 0; i < hold; i++) begin
      chk("bp_result", {23'd0, bus8.result, bus8.cout, bus8.overflow}, {23'd0, er, ec, ev});
      chk("bp_start_ready", {31'd0, bus8.start_ready}, 32'd0);
      chk("bp_res_valid", {31'd0, bus8.res_valid}, 32'd1);
      bus8.start_valid = 1'b1;
      bus8.a = 8'h01; bus8.b = 8'h01; bus8.op = 1'b0;
      tick();
    end
    bus8.start_valid = 1'b0;
    bus8.res_ready = 1'b1;
    tick();
    chk("release_res_valid", {31'd0, bus8.res_valid}, 32'd0);
    chk("release_start_ready", {31'd0, bus8.start_ready}, 32'd1);
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic op);
    logic [2:0] bb;
    logic [3:0] sum;
    logic       v;
    int n;
    bb  = op ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {3'd0, op};
    v   = (a[2] == bb[2]) && (sum[2] != a[2]);
    bus3.a = a; bus3.b = b; bus3.op = op;
    bus3.start_valid = 1'b1;
    n = 0;
    while (!bus3.start_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("start_ready3_timeout", 32'd0, 32'd1);
    sb3.push_back('{res: {5'd0, sum[2:0]}, c: sum[3], v: v});
    tick();
    bus3.start_valid = 1'b0;
    n = 0;
    while (!bus3.res_valid && n < 50) begin tick(); n++; end
    if (n == 50) chk("res_valid3_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    bus8.start_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = 1'b0; bus8.res_ready = 1'b1;
    bus3.start_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.op = 1'b0; bus3.res_ready = 1'b1;
    repeat (3) tick();
    chk("rst_start_ready", {31'd0, bus8.start_ready}, 32'd1);
    chk("rst_outputs", {22'd0, bus8.res_valid, bus8.result, bus8.cout, bus8.overflow}, 32'd0);
    rst = 1'b0;
    tick();

    issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    issue8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    issue8(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1, 5);

    // Abort an op mid-RUN; nothing is pushed since no result may appear
    bus8.a = 8'h22; bus8.b = 8'h11; bus8.op = 1'b0; bus8.start_valid = 1'b1;
    tick();
    bus8.start_valid = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {22'd0, bus8.res_valid, bus8.result, bus8.cout, bus8.overflow}, 32'd0);
    chk("midrst_start_ready", {31'd0, bus8.start_ready}, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.res_valid) chk("midrst_no_res_valid", 32'd1, 32'd0);
      tick();
    end
    issue8(8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0, 0);

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int op = 0; op < 2; op++)
          issue3(3'(a), 3'(b), 1'(op));

    repeat (4) tick();
    chk("sb8_drained", sb8.size(), 0);
    chk("sb3_drained", sb3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
